// File: rtl/pwm_fade_ctrl_if.sv
// Target-duty command channel into pwm_fade_ctrl: valid/ready with duty and step rate.
// The source owns valid/duty/rate; the sequencer answers with ready.
interface pwm_fade_ctrl_if #(
   parameter int DIV_W = 8
);
   logic             tgt_valid;
   logic [7:0]       tgt_duty;
   logic [DIV_W-1:0] tgt_rate;
   logic             tgt_ready;

   modport master (output tgt_valid, tgt_duty, tgt_rate, input tgt_ready);
   modport slave  (input tgt_valid, tgt_duty, tgt_rate, output tgt_ready);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the 8-bit pwm block: ramps duty toward a commanded target
// by +/-1 on PWM period boundaries, one step every `rate` periods.
module pwm_fade_ctrl #(
   parameter int DIV_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   pwm_fade_ctrl_if.slave tgt,
   input  logic           hold,
   input  logic           abort,
   output logic [7:0]     duty,
   output logic           period_start,
   output logic           busy,
   output logic           done
);
   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, RAMP} state_t;

   typedef struct packed {
      logic [7:0]       duty;
      logic [DIV_W-1:0] rate;
   } cmd_t;

   state_t           state;
   cmd_t             cmd;
   logic [7:0]       phase;
   logic [DIV_W-1:0] div_cnt;
   logic             boundary;
   logic             accept;
   logic [7:0]       duty_step;

   // phase mirrors the pwm counter; the 255->0 edge is where din may change
   assign boundary     = (phase == 8'hFF);
   assign tgt.tgt_ready = rst && (state == IDLE);
   assign period_start = rst && (phase == 8'h00);
   assign accept       = tgt.tgt_valid && tgt.tgt_ready;

   // Saturating one-step move toward the target; never wraps past 0 or 255.
   always_comb begin
      duty_step = duty;
      if (cmd.duty > duty)
         duty_step = duty + 8'd1;
      else if (cmd.duty < duty)
         duty_step = duty - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cmd     <= '0;
         phase   <= 8'h00;
         div_cnt <= '0;
         duty    <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         phase <= phase + 8'd1;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (tgt.tgt_duty == duty) begin
                     done <= 1'b1;
                  end else begin
                     cmd.duty <= tgt.tgt_duty;
                     cmd.rate <= tgt.tgt_rate;
                     div_cnt  <= '0;
                     state    <= RAMP;
                     busy     <= 1'b1;
                  end
               end
            end
            RAMP: begin
               // abort wins over any step scheduled on the same edge
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (boundary && !hold) begin
                  if (cmd.rate == '0) begin
                     duty  <= cmd.duty;
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (div_cnt == cmd.rate - DIV_ONE) begin
                     duty    <= duty_step;
                     div_cnt <= '0;
                     if (duty_step == cmd.duty) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     div_cnt <= div_cnt + DIV_ONE;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: period-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_pwm_fade_ctrl;
   localparam int DIV_W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hold = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] duty;
   logic       period_start, busy, done;

   pwm_fade_ctrl_if #(.DIV_W(DIV_W)) tgt();

   pwm_fade_ctrl #(.DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .tgt(tgt), .hold(hold), .abort(abort),
      .duty(duty), .period_start(period_start), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Reference: counts periods elapsed since the last step and moves duty when enough
   // periods have gone by; phase is simply cycles since reset modulo 256.
   int m_phase = 0, m_duty = 0, m_tgt = 0, m_rate = 0, m_periods = 0;
   bit m_active = 0, m_done = 0, mon_en = 0;

   always @(posedge clk) begin
      if (!rst) begin
         m_phase = 0; m_duty = 0; m_active = 0; m_done = 0; m_periods = 0;
         mon_en = 1;
      end else begin
         m_done = 0;
         if (!m_active) begin
            if (tgt.tgt_valid) begin
               if (int'(tgt.tgt_duty) == m_duty) m_done = 1;
               else begin
                  m_active = 1; m_tgt = tgt.tgt_duty; m_rate = tgt.tgt_rate; m_periods = 0;
               end
            end
         end else if (abort) begin
            m_active = 0;
         end else if (m_phase == 255 && !hold) begin
            m_periods++;
            if (m_rate == 0) m_duty = m_tgt;
            else if (m_periods == m_rate) begin
               m_periods = 0;
               m_duty += (m_tgt > m_duty) ? 1 : -1;
            end
            if (m_duty == m_tgt) begin
               m_active = 0; m_done = 1;
            end
         end
         m_phase = (m_phase + 1) % 256;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("duty", int'(duty), m_duty);
         check("busy", int'(busy), int'(m_active));
         check("done", int'(done), int'(m_done));
         check("tgt_ready", int'(tgt.tgt_ready), int'(rst && !m_active));
         check("period_start", int'(period_start), int'(rst && m_phase == 0));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_phase(int p);
      int n = 0;
      while (m_phase != p && n < 400) begin tick(); n++; end
      if (m_phase != p) check("wait_phase_timeout", m_phase, p);
   endtask

   task automatic wait_duty(int v);
      int n = 0;
      while (int'(duty) != v && n < 3000) begin tick(); n++; end
      if (int'(duty) != v) check("wait_duty_timeout", int'(duty), v);
   endtask

   task automatic send(int d, int r);
      tgt.tgt_valid = 1'b1;
      tgt.tgt_duty  = d[7:0];
      tgt.tgt_rate  = r[DIV_W-1:0];
      tick();
      tgt.tgt_valid = 1'b0;
   endtask

   task automatic jump(int d);
      wait_phase(0);
      send(d, 0);
      repeat (300) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bc, dc, zc, chg, b, mx, done_b, dec, prev, other;
      tgt.tgt_valid = 1'b0;
      tgt.tgt_duty  = 8'd0;
      tgt.tgt_rate  = '0;

      // reset held 5 cycles
      repeat (5) begin
         tick();
         check("rst_duty", int'(duty), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_done", int'(done), 0);
         check("rst_ready", int'(tgt.tgt_ready), 0);
      end
      rst = 1'b1; #1;
      for (int k = 0; k <= 512; k++) begin
         if (k == 0 || k == 256 || k == 512) check("ps_period", int'(period_start), 1);
         else if (k == 1 || k == 255) check("ps_gap", int'(period_start), 0);
         tick();
      end

      // jump to 100 at rate 0; command lands as phase becomes 10
      wait_phase(9);
      send(100, 0);
      bc = 0; dc = 0; zc = 0; chg = -1;
      for (int i = 0; i < 300; i++) begin
         if (busy) bc++;
         if (done) dc++;
         if (duty == 8'd0) zc++;
         if (duty == 8'd100 && chg < 0) chg = m_phase;
         tick();
      end
      check("jump_change_phase", chg, 0);
      check("jump_busy_cycles", bc, 246);
      check("jump_zero_cycles", zc, 246);
      check("jump_done_count", dc, 1);
      check("jump_duty", int'(duty), 100);

      // ramp up 0 -> 4 at rate 2
      jump(0);
      wait_phase(0);
      send(4, 2);
      b = 0; dc = 0; mx = 0;
      for (int i = 0; i < 8 * 256 + 20; i++) begin
         if (m_phase == 0) begin
            b++;
            if (b == 2 || b == 4 || b == 6 || b == 8) check("up_step", int'(duty), b / 2);
         end
         if (done) dc++;
         if (int'(duty) > mx) mx = duty;
         tick();
      end
      check("up_done_count", dc, 1);
      check("up_max", mx, 4);
      check("up_final", int'(duty), 4);

      // ramp down 200 -> 195 at rate 1, hold over boundaries 3..5
      jump(200);
      wait_phase(0);
      send(195, 1);
      b = 0; done_b = -1;
      for (int i = 0; i < 9 * 256; i++) begin
         if (m_phase == 0) begin
            b++;
            if (b == 2) check("down_b2", int'(duty), 198);
            if (b >= 3 && b <= 5) check("hold_frozen", int'(duty), 198);
            if (b == 2) hold = 1'b1;
            if (b == 5) hold = 1'b0;
         end
         if (done) done_b = b;
         tick();
      end
      check("hold_done_boundary", done_b, 8);
      check("hold_final", int'(duty), 195);

      // abort and ignored command while ramping 0 -> 50
      jump(0);
      wait_phase(0);
      send(50, 1);
      wait_duty(3);
      wait_phase(100);
      tgt.tgt_valid = 1'b1; tgt.tgt_duty = 8'd10; tgt.tgt_rate = '0;
      check("ignored_ready", int'(tgt.tgt_ready), 0);
      tick();
      tgt.tgt_valid = 1'b0;
      wait_duty(7);
      wait_phase(50);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_duty", int'(duty), 7);
      check("abort_busy", int'(busy), 0);
      check("abort_ready", int'(tgt.tgt_ready), 1);
      dc = 0;
      for (int i = 0; i < 600; i++) begin
         if (done) dc++;
         tick();
      end
      check("abort_no_done", dc, 0);
      check("abort_duty_held", int'(duty), 7);
      send(7, 3);
      check("equal_done", int'(done), 1);
      check("equal_busy", int'(busy), 0);
      tick();
      check("equal_done_width", int'(done), 0);

      // endpoints: 250 -> 255 at rate 1, then 255 -> 0 at rate 0
      jump(250);
      wait_phase(0);
      send(255, 1);
      dec = 0; dc = 0; prev = duty;
      for (int i = 0; i < 6 * 256 + 10; i++) begin
         if (int'(duty) < prev) dec++;
         prev = duty;
         if (done) dc++;
         tick();
      end
      check("top_no_decrease", dec, 0);
      check("top_final", int'(duty), 255);
      check("top_done_count", dc, 1);
      wait_phase(0);
      send(0, 0);
      other = 0;
      for (int i = 0; i < 300; i++) begin
         if (duty != 8'd0 && duty != 8'd255) other++;
         tick();
      end
      check("bottom_no_intermediate", other, 0);
      check("bottom_final", int'(duty), 0);

      // reset mid-ramp 0 -> 255
      wait_phase(0);
      send(255, 1);
      wait_duty(3);
      wait_phase(100);
      rst = 1'b0;
      tick();
      check("midrst_duty", int'(duty), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_ready", int'(tgt.tgt_ready), 0);
      check("midrst_ps_forced", int'(period_start), 0);
      rst = 1'b1; #1;
      check("midrst_phase0", int'(period_start), 1);
      tick();
      check("midrst_phase1", int'(period_start), 0);
      check("midrst_duty_after", int'(duty), 0);
      check("midrst_busy_after", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle sequencer for the team's 8-bit `pwm` block. It accepts target duty commands over a valid/ready handshake and drives the `pwm` `din` input. It steps the duty toward each target by ±1 at PWM period boundaries, at a programmable rate, to produce glitch-free fades. It shares `clk`/`rst` with the `pwm` instance and tracks period boundaries with its own free-running 8-bit phase counter, which stays aligned with the `pwm` counter because both leave reset on the same edge.

## Interface
- `DIV_W`, 8, width of the rate field: number of PWM periods per ±1 duty step.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `tgt_valid` in 1: target command valid.
- `tgt_duty` in 8: target duty, 0–255.
- `tgt_rate` in DIV_W: periods per step; 0 means jump to target at the next boundary.
- `tgt_ready` out 1: command accepted on an edge where `tgt_valid && tgt_ready`.
- `hold` in 1: freeze the ramp; boundaries seen while high are not counted.
- `abort` in 1: cancel the ramp in progress; duty stays at its current value.
- `duty` out 8: connects to `pwm.din`.
- `period_start` out 1: high during the cycle where phase == 0.
- `busy` out 1: high while in RAMP.
- `done` out 1: one-cycle pulse when duty reaches the target.

## Operation
- Phase counter: 8-bit, increments every cycle, wraps 255→0. A boundary is an edge taken with phase == 255.
- States: IDLE, RAMP.
  - IDLE: `tgt_ready` = 1. On accept, latch target and rate, clear the divider count, and go to RAMP.
  - Accept with `tgt_duty == duty`: go straight back to IDLE and pulse `done` the next cycle. Duty does not change.
- RAMP, at each boundary with `hold` low:
  - If rate == 0: load duty with the target and complete.
  - Else if div_cnt == rate−1: duty steps ±1 toward the target, and div_cnt returns to 0.
  - Otherwise div_cnt increments.
  - When the new duty equals the target: return to IDLE and pulse `done` for one cycle.
- Arithmetic: duty never wraps. It moves monotonically toward the target, and endpoints 0 and 255 are reached exactly.
- `abort` in RAMP: next state is IDLE, duty unchanged, no `done`. `abort` has priority over a step on the same edge. `abort` in IDLE has no effect.
- `tgt_valid` in RAMP is ignored, since `tgt_ready` = 0. The command stays pending at the source.
- `tgt_valid` and `abort` together in IDLE: the command is accepted.
- `hold` has no effect in IDLE and does not block acceptance.

## Timing
- Reset values, registered on the edge with `rst` low: duty = 0, phase = 0, state = IDLE, div_cnt = 0, `busy` = 0, `done` = 0.
- `tgt_ready` and `period_start` are forced to 0 while `rst` is low.
- After `rst` rises, the first cycle has phase = 0 and `period_start` = 1. `period_start` then repeats every 256 cycles.
- Duty changes only on boundary edges (phase 255→0). The `pwm` block therefore sees a constant `din` for a full period.
- Accept-to-first-change latency equals (cycles to next boundary) + (rate−1)×256 cycles, with rate 0 treated as rate 1.
- `busy` rises on the edge after accept and falls on the completing edge, in the same cycle that `done` rises.
- `done` is exactly one cycle wide.
- Back-to-back commands: `tgt_ready` is high in the cycle after `done`, so a new command can be accepted there.
- `rst` low mid-ramp: all state returns to reset values on that edge, and any partial divider count is discarded.

## Test plan
- Reset: hold `rst` low 5 cycles.
  - During reset: duty = 0, `busy` = 0, `done` = 0, `tgt_ready` = 0.
  - After release: `period_start` high at release+0, +256, +512.
- Jump: accept duty 100, rate 0 at phase 10.
  - Duty stays 0 until the phase 255→0 edge, then reads 100.
  - `done` pulses for 1 cycle, and `busy` is high for 246 cycles.
- Ramp up: from 0, accept duty 4, rate 2 at phase 0.
  - Duty reads 1, 2, 3, 4 after the 2nd, 4th, 6th and 8th boundaries.
  - `done` pulses exactly once, and duty never exceeds 4.
- Ramp down with hold: from 200, accept duty 195, rate 1, then assert `hold` for 3 periods after the 2nd step.
  - Duty stays frozen at 198 during the hold.
  - Duty reaches 195 three periods later than without the hold.
- Abort and ignore: while ramping 0→50 at rate 1:
  - Pulse `tgt_valid` with duty 10: it is ignored, `tgt_ready` = 0.
  - `abort` at duty 7: duty stays 7, state is IDLE, no `done`.
  - A new command 7→7 pulses `done` the next cycle.
- Endpoints and reset: ramp 250→255 at rate 1, then 255→0 at rate 0.
  - Neither ramp wraps.
  - `rst` low mid-ramp 0→255 gives duty = 0, phase = 0, and `busy` = 0 on the next edge.
